// File: rtl/start_lights_seq_fsm.sv
// Start-lights sequencer: tick-paced thermometer fill, hold until the random delay
// expires, then all lamps out with a go pulse; jump starts divert to a timed fault flash.
module start_lights_seq_fsm #(
    parameter int N_LIGHTS        = 10,
    parameter int TICKS_PER_LIGHT = 1,
    parameter int FILL_DIR        = 0,
    parameter int JUMP_DETECT     = 1,
    parameter int FAULT_TICKS     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                trigger,
    input  logic                delay_done,
    output logic                lfsr_en,
    output logic                start_delay,
    output logic [N_LIGHTS-1:0] lights,
    output logic                go,
    output logic                jump_start,
    output logic                busy
);

    localparam int IDX_W = $clog2(N_LIGHTS + 1);
    localparam logic [IDX_W-1:0] IDX_FULL   = IDX_W'(N_LIGHTS);
    localparam logic [3:0]       TCNT_LAST  = 4'(TICKS_PER_LIGHT - 1);
    localparam logic [7:0]       FCNT_LAST  = 8'(FAULT_TICKS - 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_HOLD, S_OUT, S_FAULT} state_t;

    state_t              state, state_nxt;
    logic                trig_prev;
    logic                start_req, start_req_nxt;
    logic [IDX_W-1:0]    light_idx, light_idx_nxt;
    logic [3:0]          tick_cnt, tick_cnt_nxt;
    logic [7:0]          fault_cnt, fault_cnt_nxt;
    logic [N_LIGHTS-1:0] lights_nxt;
    logic                lfsr_en_nxt, start_delay_nxt, go_nxt, jump_start_nxt, busy_nxt;
    logic                press, jump;

    // Shifting a one in from the fill end keeps the pattern a thermometer.
    function automatic logic [N_LIGHTS-1:0] add_lamp(input logic [N_LIGHTS-1:0] cur);
        if (FILL_DIR == 0) return {cur[N_LIGHTS-2:0], 1'b1};
        else               return {1'b1, cur[N_LIGHTS-1:1]};
    endfunction

    assign press = trig_prev & ~trigger;
    assign jump  = press && (JUMP_DETECT != 0);

    always_comb begin
        state_nxt       = state;
        start_req_nxt   = start_req;
        light_idx_nxt   = light_idx;
        tick_cnt_nxt    = tick_cnt;
        fault_cnt_nxt   = fault_cnt;
        lights_nxt      = lights;
        lfsr_en_nxt     = lfsr_en;
        start_delay_nxt = 1'b0;
        go_nxt          = 1'b0;
        jump_start_nxt  = jump_start;

        case (state)
            S_IDLE: begin
                if (tick && start_req) begin
                    state_nxt     = S_FILL;
                    lights_nxt    = add_lamp('0);
                    lfsr_en_nxt   = 1'b1;
                    light_idx_nxt = IDX_W'(1);
                    tick_cnt_nxt  = '0;
                    start_req_nxt = 1'b0;
                end else if (press) begin
                    start_req_nxt = 1'b1;
                end
            end
            S_FILL: begin
                // A jump start wins even over the tick that would finish the fill.
                if (jump) begin
                    state_nxt      = S_FAULT;
                    lights_nxt     = '1;
                    jump_start_nxt = 1'b1;
                    lfsr_en_nxt    = 1'b0;
                    fault_cnt_nxt  = '0;
                end else if (tick) begin
                    if (tick_cnt == TCNT_LAST) begin
                        tick_cnt_nxt = '0;
                        if (light_idx < IDX_FULL) begin
                            lights_nxt    = add_lamp(lights);
                            light_idx_nxt = light_idx + IDX_W'(1);
                        end else begin
                            state_nxt       = S_HOLD;
                            lfsr_en_nxt     = 1'b0;
                            start_delay_nxt = 1'b1;
                        end
                    end else begin
                        tick_cnt_nxt = tick_cnt + 4'd1;
                    end
                end
            end
            S_HOLD: begin
                if (delay_done) begin
                    state_nxt  = S_OUT;
                    lights_nxt = '0;
                    go_nxt     = 1'b1;
                end else if (jump) begin
                    state_nxt      = S_FAULT;
                    lights_nxt     = '1;
                    jump_start_nxt = 1'b1;
                    lfsr_en_nxt    = 1'b0;
                    fault_cnt_nxt  = '0;
                end
            end
            S_OUT: begin
                state_nxt = S_IDLE;
            end
            S_FAULT: begin
                if (tick) begin
                    if (fault_cnt == FCNT_LAST) begin
                        state_nxt      = S_IDLE;
                        lights_nxt     = '0;
                        jump_start_nxt = 1'b0;
                    end else begin
                        lights_nxt    = ~lights;
                        fault_cnt_nxt = fault_cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_nxt      = S_IDLE;
                lights_nxt     = '0;
                lfsr_en_nxt    = 1'b0;
                jump_start_nxt = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            trig_prev   <= 1'b1;
            start_req   <= 1'b0;
            light_idx   <= '0;
            tick_cnt    <= '0;
            fault_cnt   <= '0;
            lights      <= '0;
            lfsr_en     <= 1'b0;
            start_delay <= 1'b0;
            go          <= 1'b0;
            jump_start  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            trig_prev   <= trigger;
            start_req   <= start_req_nxt;
            light_idx   <= light_idx_nxt;
            tick_cnt    <= tick_cnt_nxt;
            fault_cnt   <= fault_cnt_nxt;
            lights      <= lights_nxt;
            lfsr_en     <= lfsr_en_nxt;
            start_delay <= start_delay_nxt;
            go          <= go_nxt;
            jump_start  <= jump_start_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_start_lights_seq_fsm.sv
// Bench for start_lights_seq_fsm: two configurations share the stimulus and are each
// compared every clock against a tick-count reference model.
module tb_start_lights_seq_fsm;

    logic clk = 1'b0;
    logic rst, tick, trigger, delay_done;
    logic [4:0] lights0;
    logic [9:0] lights1;
    logic lfsr0, sd0, go0, js0, busy0;
    logic lfsr1, sd1, go1, js1, busy1;

    always #5 clk = ~clk;

    start_lights_seq_fsm #(.N_LIGHTS(5), .TICKS_PER_LIGHT(2), .FILL_DIR(0),
                           .JUMP_DETECT(1), .FAULT_TICKS(4)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .delay_done(delay_done),
        .lfsr_en(lfsr0), .start_delay(sd0), .lights(lights0), .go(go0),
        .jump_start(js0), .busy(busy0));

    start_lights_seq_fsm #(.N_LIGHTS(10), .TICKS_PER_LIGHT(1), .FILL_DIR(1),
                           .JUMP_DETECT(0), .FAULT_TICKS(8)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .delay_done(delay_done),
        .lfsr_en(lfsr1), .start_delay(sd1), .lights(lights1), .go(go1),
        .jump_start(js1), .busy(busy1));

    typedef struct packed { int n; int t; int dir; int jd; int ft; } cfg_t;
    // mode: 0 idle, 1 filling, 2 holding, 3 lamps-out clock, 4 fault flash
    typedef struct packed { int mode; bit req; bit prev; int ticks; int fticks; bit sd; bit go; } mdl_t;

    localparam cfg_t C0 = '{n: 5,  t: 2, dir: 0, jd: 1, ft: 4};
    localparam cfg_t C1 = '{n: 10, t: 1, dir: 1, jd: 0, ft: 8};

    mdl_t m0, m1;
    int n_err = 0;
    int n_chk = 0;
    int sd_cnt, go_cnt;

    function automatic mdl_t mstep(cfg_t c, mdl_t m, bit r, bit tk, bit tg, bit dd);
        mdl_t n = m;
        bit press;
        n.sd = 1'b0;
        n.go = 1'b0;
        if (r) begin
            n.mode = 0; n.req = 1'b0; n.prev = 1'b1; n.ticks = 0; n.fticks = 0;
            return n;
        end
        press  = m.prev && !tg;
        n.prev = tg;
        case (m.mode)
            0: if (tk && m.req) begin n.mode = 1; n.ticks = 0; n.req = 1'b0; end
               else if (press) n.req = 1'b1;
            1: if (press && c.jd != 0) begin n.mode = 4; n.fticks = 0; end
               else if (tk) begin
                   n.ticks = m.ticks + 1;
                   if (n.ticks == c.n * c.t) begin n.mode = 2; n.sd = 1'b1; end
               end
            2: if (dd) begin n.mode = 3; n.go = 1'b1; end
               else if (press && c.jd != 0) begin n.mode = 4; n.fticks = 0; end
            3: n.mode = 0;
            default: if (tk) begin
                   n.fticks = m.fticks + 1;
                   if (n.fticks == c.ft) n.mode = 0;
               end
        endcase
        return n;
    endfunction

    function automatic logic [15:0] thermo(cfg_t c, int k);
        logic [15:0] mask;
        mask = (16'd1 << k) - 16'd1;
        if (c.dir != 0) mask = mask << (c.n - k);
        return mask;
    endfunction

    // Expected {lights, lfsr_en, start_delay, go, jump_start, busy}
    function automatic logic [20:0] mexp(cfg_t c, mdl_t m);
        logic [15:0] lt;
        int k;
        lt = 16'h0;
        case (m.mode)
            1: begin
                k = m.ticks / c.t + 1;
                if (k > c.n) k = c.n;
                lt = thermo(c, k);
            end
            2: lt = thermo(c, c.n);
            4: lt = (m.fticks % 2 == 0) ? thermo(c, c.n) : 16'h0;
            default: lt = 16'h0;
        endcase
        return {lt, (m.mode == 1), m.sd, m.go, (m.mode == 4), (m.mode != 0)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit tk, input bit tg, input bit dd);
        rst = r; tick = tk; trigger = tg; delay_done = dd;
        @(posedge clk);
        m0 = mstep(C0, m0, r, tk, tg, dd);
        m1 = mstep(C1, m1, r, tk, tg, dd);
        #1;
        chk("model_cfg0", {11'd0, lights0, lfsr0, sd0, go0, js0, busy0}, {11'd0, mexp(C0, m0)});
        chk("model_cfg1", {11'd0, 6'd0, lights1, lfsr1, sd1, go1, js1, busy1}, {11'd0, mexp(C1, m1)});
        if (sd0) sd_cnt++;
        if (go0) go_cnt++;
    endtask

    typedef struct {
        bit r, tk, tg, dd;
        logic [4:0] lt;
        bit le, sd, go, js, bz;
    } vec_t;

    vec_t tbl[18];

    initial begin
        tbl[0]  = '{1, 0, 1, 0, 5'b00000, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 1, 0, 5'b00001, 1, 0, 0, 0, 1};
        tbl[3]  = '{0, 1, 1, 0, 5'b00001, 1, 0, 0, 0, 1};
        tbl[4]  = '{0, 1, 1, 0, 5'b00011, 1, 0, 0, 0, 1};
        tbl[5]  = '{0, 0, 1, 0, 5'b00011, 1, 0, 0, 0, 1};
        tbl[6]  = '{0, 1, 1, 0, 5'b00011, 1, 0, 0, 0, 1};
        tbl[7]  = '{0, 1, 1, 0, 5'b00111, 1, 0, 0, 0, 1};
        tbl[8]  = '{0, 1, 1, 0, 5'b00111, 1, 0, 0, 0, 1};
        tbl[9]  = '{0, 1, 1, 0, 5'b01111, 1, 0, 0, 0, 1};
        tbl[10] = '{0, 1, 1, 0, 5'b01111, 1, 0, 0, 0, 1};
        tbl[11] = '{0, 1, 1, 0, 5'b11111, 1, 0, 0, 0, 1};
        tbl[12] = '{0, 1, 1, 0, 5'b11111, 1, 0, 0, 0, 1};
        tbl[13] = '{0, 1, 1, 0, 5'b11111, 0, 1, 0, 0, 1};
        tbl[14] = '{0, 0, 1, 0, 5'b11111, 0, 0, 0, 0, 1};
        tbl[15] = '{0, 1, 1, 0, 5'b11111, 0, 0, 0, 0, 1};
        tbl[16] = '{0, 0, 1, 1, 5'b00000, 0, 0, 1, 0, 1};
        tbl[17] = '{0, 0, 1, 0, 5'b00000, 0, 0, 0, 0, 0};

        rst = 1'b1; tick = 1'b0; trigger = 1'b1; delay_done = 1'b0;
        m0 = '0; m1 = '0;
        sd_cnt = 0; go_cnt = 0;

        // Clean run from the vector table
        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].r, tbl[i].tk, tbl[i].tg, tbl[i].dd);
            chk($sformatf("tbl_%0d", i), {lights0, lfsr0, sd0, go0, js0, busy0},
                {tbl[i].lt, tbl[i].le, tbl[i].sd, tbl[i].go, tbl[i].js, tbl[i].bz});
        end

        // Long hold before delay_done, then busy drops one clock after go
        cyc(1, 0, 1, 0); cyc(0, 0, 0, 0);
        for (int i = 0; i <= 10; i++) cyc(0, 1, 1, 0);
        for (int i = 0; i < 37; i++) cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        chk("long_hold_go", {lights0, go0, busy0}, {5'b00000, 1'b1, 1'b1});
        cyc(0, 0, 1, 0);
        chk("long_hold_idle", {go0, busy0}, 2'b00);

        // Jump start at three lamps
        sd_cnt = 0;
        cyc(1, 0, 1, 0); cyc(0, 0, 0, 0);
        for (int i = 0; i <= 4; i++) cyc(0, 1, 1, 0);
        chk("jump_pre", {27'd0, lights0}, 32'b00111);
        cyc(0, 0, 0, 0);
        chk("jump_entry", {lights0, js0, lfsr0}, {5'b11111, 1'b1, 1'b0});
        cyc(0, 1, 0, 0); chk("flash_1", {lights0, js0}, {5'b00000, 1'b1});
        cyc(0, 1, 0, 0); chk("flash_2", {lights0, js0}, {5'b11111, 1'b1});
        cyc(0, 1, 0, 0); chk("flash_3", {lights0, js0}, {5'b00000, 1'b1});
        cyc(0, 1, 0, 0); chk("flash_end", {lights0, js0, busy0}, {5'b00000, 1'b0, 1'b0});
        chk("jump_no_start_delay", sd_cnt, 0);

        // delay_done and press together in HOLD: clean start wins
        cyc(1, 0, 1, 0); cyc(0, 0, 0, 0);
        for (int i = 0; i <= 10; i++) cyc(0, 1, 1, 0);
        cyc(0, 0, 0, 1);
        chk("hold_tie", {go0, js0}, 2'b10);

        // Reset during HOLD, then a stray delay_done
        cyc(1, 0, 1, 0); cyc(0, 0, 0, 0);
        for (int i = 0; i <= 10; i++) cyc(0, 1, 1, 0);
        chk("pre_rst_hold", {lights0, busy0}, {5'b11111, 1'b1});
        cyc(1, 0, 1, 0);
        chk("rst_in_hold", {lights0, lfsr0, sd0, go0, js0, busy0}, 10'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 1);
            chk("rst_no_go", {go0, busy0}, 2'b00);
        end

        // Downward fill, one tick per lamp, presses in FILL ignored
        cyc(1, 0, 1, 0); cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 0);
        chk("dir1_first", {22'd0, lights1}, 32'b1000000000);
        cyc(0, 0, 0, 0);
        chk("dir1_press_ignored", {lfsr1, js1}, 2'b10);
        for (int i = 0; i < 9; i++) cyc(0, 1, 1, 0);
        chk("dir1_full", {lights1, lfsr1}, {10'h3FF, 1'b1});
        cyc(0, 1, 1, 0);
        chk("dir1_hold", {lfsr1, sd1}, 2'b01);

        // Key held low for a whole run, delay_done pulsed in IDLE
        cyc(1, 0, 1, 0);
        sd_cnt = 0; go_cnt = 0;
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 20; i++) cyc(0, i % 2, 0, i % 3 == 0);
        chk("held_one_delay", sd_cnt, 1);
        chk("held_one_go", go_cnt, 1);
        chk("held_idle", {27'd0, lights0, busy0} , 32'd0);

        // Randomised traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            automatic bit tg = trigger;
            if ($urandom_range(0, 7) == 0) tg = ~tg;
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, tg,
                $urandom_range(0, 9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
